// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk into a pixel strobe and produces registered VGA sync/blank/count outputs.
// The strobe is registered; counts and decodes change one clk after the strobe cycle. run=0 freezes the raster and gates the pulses.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       run,
  output logic       counterEnable,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       lineStart,
  output logic       frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_START  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYN_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_BP_START  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS_END   = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYN_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYN_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    HS_ACT = 2'd0,
    HS_FP  = 2'd1,
    HS_SYN = 2'd2,
    HS_BP  = 2'd3
  } h_state_e;

  h_state_e         hstate_q, hstate_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             ce_q, ce_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             bright_q, bright_d;
  logic             line_q, line_d, frame_q, frame_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      div_q    <= '0;
      ce_q     <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hstate_q <= HS_ACT;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      bright_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      ce_q     <= ce_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hstate_q <= hstate_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    div_d    = div_q;
    ce_d     = 1'b0;
    h_d      = h_q;
    v_d      = v_q;
    hstate_d = hstate_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    bright_d = bright_q;
    line_d   = 1'b0;
    frame_d  = 1'b0;

    if (run) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      ce_d  = (div_d == DIV_LAST);
    end

    // A strobe already delivered to consumers is always honoured, so a pause
    // right after it neither drops nor repeats that pixel.
    if (ce_q) begin
      h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end

      unique case (hstate_q)
        HS_ACT:  if (h_d == H_FP_START)  hstate_d = HS_FP;
        HS_FP:   if (h_d == H_SYN_START) hstate_d = HS_SYN;
        HS_SYN:  if (h_d == H_BP_START)  hstate_d = HS_BP;
        HS_BP:   if (h_d == 10'd0)       hstate_d = HS_ACT;
        default: hstate_d = HS_ACT;
      endcase

      hsync_d  = (hstate_d != HS_SYN);
      vsync_d  = !((v_d >= V_SYN_START) && (v_d < V_SYN_END));
      bright_d = (h_d < H_FP_START) && (v_d < V_VIS_END);
      line_d   = run && (h_d == 10'd0);
      frame_d  = run && (h_d == 10'd0) && (v_d == 10'd0);
    end
  end

  assign counterEnable = ce_q;
  assign hCount        = h_q;
  assign vCount        = v_q;
  assign hSync         = hsync_q;
  assign vSync         = vsync_q;
  assign bright        = bright_q;
  assign lineStart     = line_q;
  assign frameStart    = frame_q;

endmodule
